// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame arbiter: frame width, timing defaults,
// arbiter state encoding and the owner-index width helper.
package spi_pkg;

  localparam int SPI_FRAME_W        = 392;
  localparam int SPI_GAP_CYCLES     = 4;
  localparam int SPI_TIMEOUT_CYCLES = 4096;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DONE = 3'd2,
    RESPOND   = 3'd3,
    GAP       = 3'd4
  } arb_state_t;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int owner_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr, with wrap.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any                         = 1'b1;
        idx                         = IW'((int'(ptr) + k) % N);
        grant[(int'(ptr) + k) % N]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_frame_arbiter.sv
// Round-robin owner of a shared full-frame SPI master: grants one frame at a time,
// watches for done with a timeout, returns the RX frame and enforces an idle gap.
module spi_frame_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int FRAME_W        = SPI_FRAME_W,
  parameter int GAP_CYCLES     = SPI_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = SPI_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*FRAME_W-1:0] req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [FRAME_W-1:0]         rsp_data,
  output logic                       rsp_err,
  output logic                       m_start,
  output logic                       m_abort,
  output logic [FRAME_W-1:0]         m_data_in,
  input  logic [FRAME_W-1:0]         m_data_out,
  input  logic                       m_busy,
  input  logic                       m_done,
  output arb_state_t                 dbg_state
);

  // Handshake: req_ready[i] is high for exactly the one IDLE cycle in which
  // requester i's req_valid/req_data are taken; rsp_valid is a one-cycle pulse
  // with no back-pressure, and rsp_data/rsp_err stay put until the next response.

  localparam int IW = owner_w(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    GAP_LAST = 8'(GAP_CYCLES - 1);

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [TW-1:0]       to_cnt_q, to_cnt_d;
  logic [7:0]          gap_cnt_q, gap_cnt_d;
  logic                m_start_d, m_abort_d, rsp_err_d;
  logic [NUM_REQ-1:0]  rsp_valid_d;
  logic [FRAME_W-1:0]  m_data_in_d, rsp_data_d;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    to_cnt_d    = to_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    m_start_d   = 1'b0;
    m_abort_d   = 1'b0;
    rsp_valid_d = '0;
    rsp_err_d   = rsp_err;
    rsp_data_d  = rsp_data;
    m_data_in_d = m_data_in;
    req_ready   = '0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_ready   = pick_grant;
          m_data_in_d = req_data[int'(pick_idx) * FRAME_W +: FRAME_W];
          owner_d     = pick_idx;
          ptr_d       = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          // Start goes out registered in the first ISSUE cycle when the master is free.
          m_start_d   = ~m_busy;
          to_cnt_d    = '0;
          state_d     = ISSUE;
        end
      end

      ISSUE: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (m_start) begin
          state_d = WAIT_DONE;
        end else if (!m_busy) begin
          m_start_d = 1'b1;
          to_cnt_d  = '0;
        end
      end

      WAIT_DONE: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (m_done) begin
          rsp_data_d  = m_data_out;
          rsp_err_d   = 1'b0;
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          state_d     = RESPOND;
        end else if (to_cnt_q == TO_LAST) begin
          m_abort_d   = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          state_d     = RESPOND;
        end
      end

      RESPOND: begin
        gap_cnt_d = '0;
        state_d   = GAP;
      end

      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      m_start   <= 1'b0;
      m_abort   <= 1'b0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      m_data_in <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      m_start   <= m_start_d;
      m_abort   <= m_abort_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_data  <= rsp_data_d;
      m_data_in <= m_data_in_d;
    end
  end

  assign dbg_state = state_q;

endmodule
